// File: rtl/umi_arb_pkg.sv
// Shared definitions for the UMI round-robin arbiter slice.
package umi_arb_pkg;

  localparam int UMI_PACKET_W = 256;

  // Index width for N ports; a single port still needs a 1-bit index.
  function automatic int sw_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/umi_rr_pick.sv
// Combinational round-robin pick: first requester after the last winner, with wrap.
module umi_rr_pick
  import umi_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sw_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic [N-1:0]  gnt_onehot,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  logic [SW-1:0] idx_s;

  // Walk the ring starting just past the last winner; the first set request wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx_s      = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = SW'((int'(last) + 1 + k) % N);
      if (!any && req[idx_s]) begin
        gnt_onehot[idx_s] = 1'b1;
        gnt_idx           = idx_s;
        any               = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/umi_rr_arbiter.sv
// Round-robin N:1 UMI arbiter with a one-entry registered output stage tagged by source port.
module umi_rr_arbiter
  import umi_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = UMI_PACKET_W,
  parameter int SW = sw_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*PW-1:0] in_packet,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [PW-1:0]   out_packet,
  output logic [SW-1:0]   out_src,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SW-1:0] last_r;
  logic [N-1:0]  gnt_onehot_s;
  logic [SW-1:0] gnt_idx_s;
  logic          any_s;
  logic          can_load_s;
  logic          load_s;
  logic [PW-1:0] win_packet_s;

  umi_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req        (in_valid),
    .last       (last_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .any        (any_s)
  );

  // The slot can take a packet when it is empty or draining this cycle.
  assign can_load_s   = !out_valid || out_ready;
  assign load_s       = !rst && can_load_s && any_s;
  assign win_packet_s = in_packet[int'(gnt_idx_s)*PW +: PW];

  // Only the winner sees ready, and nobody does while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst) begin
      in_ready = '0;
    end else if (can_load_s) begin
      in_ready = gnt_onehot_s;
    end else begin
      in_ready = '0;
    end
  end

  // Output stage and rotation pointer; last moves only when a requester is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
      out_src    <= '0;
      last_r     <= SW'(N - 1);
    end else if (load_s) begin
      out_valid  <= 1'b1;
      out_packet <= win_packet_s;
      out_src    <= gnt_idx_s;
      last_r     <= gnt_idx_s;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end else begin
      out_valid  <= out_valid;
    end
  end

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Scoreboard bench for umi_rr_arbiter: a reference arbitration model predicts grants and output contents.
module tb_umi_rr_arbiter;
  localparam int N  = 4;
  localparam int PW = 256;

  logic            clk;
  logic            rst;
  logic [N*PW-1:0] in_packet;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [PW-1:0]   out_packet;
  logic [1:0]      out_src;
  logic            out_valid;
  logic            out_ready;

  logic [31:0] n1_in_packet;
  logic [0:0]  n1_in_valid;
  logic [0:0]  n1_in_ready;
  logic [31:0] n1_out_packet;
  logic [0:0]  n1_out_src;
  logic        n1_out_valid;
  logic        n1_out_ready;

  umi_rr_arbiter #(.N(N), .PW(PW)) dut (
    .clk(clk), .rst(rst), .in_packet(in_packet), .in_valid(in_valid), .in_ready(in_ready),
    .out_packet(out_packet), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  umi_rr_arbiter #(.N(1), .PW(32)) dut_n1 (
    .clk(clk), .rst(rst), .in_packet(n1_in_packet), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .out_packet(n1_out_packet), .out_src(n1_out_src), .out_valid(n1_out_valid), .out_ready(n1_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    src;
    logic [PW-1:0] pkt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_valid;
  int   m_last;
  int   m_gnt;
  bit   keep[N];

  task automatic chk(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pkt();
    logic [PW-1:0] p;
    for (int w = 0; w < PW / 32; w++) p[w*32 +: 32] = $urandom();
    return p;
  endfunction

  // One clock: check DUT against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [N-1:0] er;
    int  g;
    bit  canl;
    #4;
    canl = !m_valid || out_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_last + 1 + k) % N;
      if (g < 0 && in_valid[idx]) g = idx;
    end
    er = '0;
    if (!rst && canl && g >= 0) er[g] = 1'b1;
    chk("in_ready", PW'(in_ready), PW'(er));
    chk("out_valid", PW'(out_valid), PW'(m_valid));
    if (m_valid && sb.size() > 0) begin
      chk("out_packet", out_packet, sb[0].pkt);
      chk("out_src", PW'(out_src), PW'(sb[0].src));
    end
    @(posedge clk);
    m_gnt = -1;
    if (rst) begin
      m_valid = 1'b0;
      m_last  = N - 1;
      sb.delete();
    end else begin
      if (m_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (canl && g >= 0) begin
        sb.push_back('{src: 2'(g), pkt: in_packet[g*PW +: PW]});
        m_valid = 1'b1;
        m_last  = g;
        m_gnt   = g;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  // Advance n cycles; a granted requester either presents a fresh packet or drops valid.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      step();
      if (m_gnt >= 0) begin
        if (keep[m_gnt]) in_packet[m_gnt*PW +: PW] = rnd_pkt();
        else in_valid[m_gnt] = 1'b0;
      end
    end
  endtask

  task automatic set_keep(input bit k);
    for (int i = 0; i < N; i++) keep[i] = k;
  endtask

  task automatic fill_ports();
    for (int i = 0; i < N; i++) in_packet[i*PW +: PW] = rnd_pkt();
  endtask

  initial begin
    logic [PW-1:0] a5;
    logic [7:0]    a5_byte;
    a5_byte = 8'hA5;
    a5 = {(PW/8){a5_byte}};
    rst = 1'b1;
    in_packet = '0;
    in_valid = '1;
    out_ready = 1'b1;
    n1_in_packet = 32'd0;
    n1_in_valid = 1'b0;
    n1_out_ready = 1'b1;
    m_valid = 1'b0;
    m_last = N - 1;
    set_keep(1'b0);
    @(posedge clk);
    #1;

    // Reset: in_ready forced low even with all ports valid.
    run(1);
    chk("rst_out_packet", out_packet, '0);
    chk("rst_out_src", PW'(out_src), '0);
    rst = 1'b0;
    in_valid = '0;
    run(1);

    // Single port 2 with an A5 packet.
    in_packet[2*PW +: PW] = a5;
    in_valid = 4'b0100;
    run(1);
    chk("single_pkt", out_packet, a5);
    chk("single_src", PW'(out_src), PW'(2));
    run(2);

    // Fairness from a fresh rotation.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    fill_ports();
    set_keep(1'b1);
    in_valid = '1;
    for (int i = 0; i < 6; i++) begin
      run(1);
      chk("fair_src", PW'(out_src), PW'(i % 4));
      chk("fair_valid", PW'(out_valid), PW'(1));
    end
    in_valid = '0;
    set_keep(1'b0);
    run(2);

    // Rotation skip: after 0 then 1, lone port 0 wins, then 2 beats 0.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    fill_ports();
    in_valid = 4'b0011;
    run(2);
    in_valid = 4'b0001;
    run(1);
    chk("skip_wrap_src", PW'(out_src), PW'(0));
    fill_ports();
    in_valid = 4'b0101;
    run(1);
    chk("skip_next_src", PW'(out_src), PW'(2));
    run(3);

    // Backpressure with ports 1 and 3 pending.
    fill_ports();
    out_ready = 1'b0;
    in_valid = 4'b1010;
    run(1);
    chk("bp_first_src", PW'(out_src), PW'(1));
    run(5);
    chk("bp_held_src", PW'(out_src), PW'(1));
    out_ready = 1'b1;
    run(1);
    chk("bp_reload_src", PW'(out_src), PW'(3));
    run(2);

    // Reset while a packet is held under backpressure.
    fill_ports();
    set_keep(1'b1);
    in_valid = '1;
    out_ready = 1'b0;
    run(1);
    rst = 1'b1;
    run(1);
    chk("rst_mid_valid", PW'(out_valid), PW'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    run(1);
    chk("rst_mid_first_src", PW'(out_src), PW'(0));
    run(2);
    in_valid = '0;
    run(2);

    // Single-port build behaves as a pipeline register.
    for (int k = 1; k <= 3; k++) begin
      n1_in_packet = 32'(k);
      n1_in_valid = 1'b1;
      #4;
      chk("n1_in_ready", PW'(n1_in_ready), PW'(1));
      @(posedge clk);
      #1;
      chk("n1_out_packet", PW'(n1_out_packet), PW'(k));
      chk("n1_out_src", PW'(n1_out_src), '0);
      chk("n1_out_valid", PW'(n1_out_valid), PW'(1));
    end
    n1_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("n1_drain_valid", PW'(n1_out_valid), PW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/umi_rr_arbiter.md
# umi_rr_arbiter

Round-robin arbiter that shares one UMI outbound port among N UMI requesters, e.g. several umi_gpio/AXI bridge outbound ports feeding a single switchboard queue. Each cycle it grants at most one valid requester, registers the packet in a one-entry output stage and tags it with the winning port index so the response path can route replies back. Whole packets are arbitrated; sustained throughput is one packet per cycle, with fairness across all requesters.

## Interface
Parameters:
- N, 4, number of requester ports (1..16)
- PW, 256, UMI packet width in bits
- SW, $clog2(N) (min 1), width of out_src

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_packet  input  N*PW  requester packets, port i at bits [i*PW +: PW]
- in_valid  input  N  per-port valid
- in_ready  output  N  per-port ready, combinational
- out_packet  output  PW  registered granted packet
- out_src  output  SW  index of the port that sourced out_packet
- out_valid  output  1  output stage holds a packet
- out_ready  input  1  downstream accept

## Operation
- Transfer on any port: valid && ready in the same cycle.
- can_load = !out_valid || out_ready. This means the output slot is empty or drains this cycle.
- Grant selection (combinational):
  - Search in_valid starting at index (last+1) mod N, ascending with wrap.
  - The first set bit wins. No winner if in_valid == 0.
- in_ready[i] = can_load && (i == winner). At most one bit is set; all bits are 0 when there is no winner.
- On an input transfer from port g:
  - out_packet <= in_packet[g]
  - out_src <= g
  - out_valid <= 1
  - last <= g
- On an output transfer with no input transfer in the same cycle: out_valid <= 0. out_packet and out_src hold their values.
- When an output transfer and an input transfer happen in the same cycle, the slot reloads and out_valid stays 1.
- last changes only on an input transfer. Requesters that are not granted keep their position in the rotation.
- Requester rules:
  - Requesters must hold valid and packet until ready.
  - Arbitration is re-evaluated every cycle, so a requester that drops valid early is a protocol violation. The arbiter must not hang on it; the next valid port is simply chosen.
- out_packet and out_src must not change while out_valid && !out_ready.
- N == 1: degenerates to a pipeline register; out_src is always 0.

## Timing
- Reset values:
  - out_valid = 0
  - out_packet = 0
  - out_src = 0
  - last = N-1, so port 0 has first priority after reset
  - in_ready = 0 in the reset cycle (forced low while rst is high)
- Latency: a packet accepted at cycle t appears at the output with out_valid = 1 at t+1.
- Throughput: 1 packet/cycle with out_ready held high.
- Backpressure: out_ready low with out_valid high gives in_ready = 0 on all ports. The held packet is stable.
- All N ports valid continuously: grant order is 0,1,...,N-1,0,... Worst-case wait is N-1 grants.
- Reset mid-operation: the held packet is discarded, out_valid is 0 the cycle after rst, and the rotation restarts at port 0.
- in_ready depends combinationally on out_ready. Upstream logic must not make in_valid depend on in_ready.

## Structure
- Shared package umi_arb_pkg:
  - UMI_PACKET_W = 256
  - the function for the SW width calc
- Sub-module umi_rr_pick:
  - purely combinational
  - inputs: req[N], last[SW]
  - outputs: gnt_onehot[N], gnt_idx[SW], any
- Top level contains the output register, the last pointer and the in_ready gating. Target is about 150 lines of RTL.

## Test plan
- Single port: port 2 sends packet 0xA5..A5 with out_ready=1 → out_valid at the next cycle, out_packet=0xA5..A5, out_src=2; in_ready[2] high for exactly 1 cycle.
- Fairness: N=4, all valid continuously with distinct packets, out_ready=1 → out_src sequence 0,1,2,3,0,1 and one packet per cycle with no bubbles.
- Backpressure: hold out_ready=0 for 5 cycles while ports 1 and 3 are valid → out_packet/out_src stable, all in_ready=0; release → port 1's packet drains and port 3 loads in the same cycle.
- Rotation skip: last=1, only port 0 valid → port 0 granted; then ports 0 and 2 valid → port 2 granted next.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 → out_valid=0 the next cycle; after release with all ports valid, port 0 is granted first.
- N=1 build: back-to-back packets 1,2,3 with out_ready=1 → they emerge 1,2,3 on consecutive cycles with out_src=0.
